// File: rtl/blocks_ctl_pkg.sv
// SkyHop block layer: shared screen geometry, LFSR seed and FSM states.
// Imported by blocks_ctl and blocks_lfsr.
package blocks_ctl_pkg;

  localparam int BLK_SCREEN_W = 800;
  localparam int BLK_SCREEN_H = 600;
  localparam int BLK_BLOCK_W  = 150;

  localparam logic [15:0] BLK_LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    BLK_IDLE   = 2'd0,
    BLK_UPDATE = 2'd1,
    BLK_DONE   = 2'd2
  } blk_state_t;

  // Fibonacci taps 16,14,13,11
  function automatic logic [15:0] lfsr_next(
    input logic [15:0] l
  );
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

endpackage

// File: rtl/blocks_ctl_lfsr.sv
// blocks_lfsr: 16-bit Fibonacci LFSR for platform respawn x positions.
// Advances only when i_adv is high, so the sequence is reproducible.
module blocks_lfsr
  import blocks_ctl_pkg::*;
#(
  parameter logic [15:0] SEED = BLK_LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_adv,
  output logic [15:0] o_val
);

  logic [15:0] r_l;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_l <= SEED;
    end else if (i_adv) begin
      r_l <= lfsr_next(r_l);
    end
  end

  assign o_val = r_l;

endmodule

// File: rtl/blocks_ctl.sv
// blocks_ctl: scrolls N_BLOCKS platforms once per frame, respawning at top.
// Optional BLOCKS_CTL_SPEEDUP_EN: step grows every 16th respawn, max 8.
module blocks_ctl
  import blocks_ctl_pkg::*;
#(
  parameter int          N_BLOCKS    = 4,
  parameter int          IDX_W       = 2,
  parameter int          BLOCK_W     = BLK_BLOCK_W,
  parameter int          SCREEN_W    = BLK_SCREEN_W,
  parameter int          SCREEN_H    = BLK_SCREEN_H,
  parameter int          SCROLL_STEP = 2,
  parameter logic [15:0] LFSR_SEED   = BLK_LFSR_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             module_en,
  input  logic             frame_tick,
  input  logic             scroll_req,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [10:0]      rd_xpos,
  output logic [10:0]      rd_ypos,
  output logic             busy,
  output logic             update_done,
  output logic [7:0]       spawn_cnt
);

  localparam int X_MAX = SCREEN_W - BLOCK_W;
  localparam int Y_GAP = SCREEN_H / N_BLOCKS;

  logic [10:0] r_xpos [N_BLOCKS];
  logic [10:0] r_ypos [N_BLOCKS];

  blk_state_t       r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_scr_q;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_spawn;
  logic [10:0]      r_rd_x;
  logic [10:0]      r_rd_y;

  logic [3:0]  w_step;
  logic [15:0] w_lfsr;
  logic [9:0]  w_lraw;
  logic [10:0] w_xraw;
  logic [10:0] w_xnew;
  logic [11:0] w_yn;
  logic        w_wrap;
  logic [10:0] w_ynew;
  logic        w_adv;

`ifdef BLOCKS_CTL_SPEEDUP_EN
  logic [3:0] r_step;

  assign w_step = r_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_step <= 4'(SCROLL_STEP);
    end else if (w_adv && r_spawn[3:0] == 4'hF
                 && r_step < 4'd8) begin
      r_step <= r_step + 4'd1;
    end
  end
`else
  assign w_step = 4'(SCROLL_STEP);
`endif

  blocks_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .i_adv (w_adv),
    .o_val (w_lfsr)
  );

  // x comes from the advanced value; one subtract folds it into range
  assign w_lraw = 10'(lfsr_next(w_lfsr));
  assign w_xraw = {1'b0, w_lraw};
  assign w_xnew = (w_xraw >= 11'(X_MAX))
                ? w_xraw - 11'(X_MAX) : w_xraw;

  assign w_yn   = {1'b0, r_ypos[r_idx]} + {8'd0, w_step};
  assign w_wrap = w_yn >= 12'(SCREEN_H);
  assign w_ynew = w_wrap ? 11'(w_yn - 12'(SCREEN_H))
                         : 11'(w_yn);
  assign w_adv  = (r_state == BLK_UPDATE) && r_scr_q && w_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BLK_IDLE;
      r_idx   <= '0;
      r_scr_q <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_spawn <= 8'd0;
      for (int i = 0; i < N_BLOCKS; i++) begin
        r_xpos[i] <= 11'(X_MAX / 2);
        r_ypos[i] <= 11'(i * Y_GAP);
      end
    end else begin
      unique case (r_state)
        BLK_IDLE: begin
          if (frame_tick && module_en) begin
            r_scr_q <= scroll_req;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= BLK_UPDATE;
          end
        end
        BLK_UPDATE: begin
          if (r_scr_q) begin
            r_ypos[r_idx] <= w_ynew;
            if (w_wrap) begin
              r_xpos[r_idx] <= w_xnew;
              r_spawn       <= r_spawn + 8'd1;
            end
          end
          if (r_idx == IDX_W'(N_BLOCKS - 1)) begin
            r_done  <= 1'b1;
            r_state <= BLK_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        BLK_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= BLK_IDLE;
        end
        default: begin
          r_state <= BLK_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_x <= 11'd0;
      r_rd_y <= 11'd0;
    end else begin
      r_rd_x <= r_xpos[rd_idx];
      r_rd_y <= r_ypos[rd_idx];
    end
  end

  assign rd_xpos     = r_rd_x;
  assign rd_ypos     = r_rd_y;
  assign busy        = r_busy;
  assign update_done = r_done;
  assign spawn_cnt   = r_spawn;

endmodule

// File: tb/tb_blocks_ctl.sv
// Scoreboard bench for blocks_ctl: read and update expectations are queued
// by stimulus and popped by a monitor when the DUT presents them.
module tb_blocks_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        module_en = 1'b1;
  logic        frame_tick = 1'b0;
  logic        scroll_req = 1'b0;
  logic [1:0]  rd_idx = 2'd0;
  logic [10:0] rd_xpos;
  logic [10:0] rd_ypos;
  logic        busy;
  logic        update_done;
  logic [7:0]  spawn_cnt;

  always #5 clk = ~clk;

  blocks_ctl dut (
    .clk         (clk),
    .rst         (rst),
    .module_en   (module_en),
    .frame_tick  (frame_tick),
    .scroll_req  (scroll_req),
    .rd_idx      (rd_idx),
    .rd_xpos     (rd_xpos),
    .rd_ypos     (rd_ypos),
    .busy        (busy),
    .update_done (update_done),
    .spawn_cnt   (spawn_cnt)
  );

  typedef struct {
    int          tag;
    logic [10:0] x;
    logic [10:0] y;
    logic [7:0]  sc;
  } rd_exp_t;

  rd_exp_t rq[$];
  int      dq[$];
  int      checks = 0;
  int      errors = 0;
  int      bcnt = 0;
  logic    rd_vld = 1'b0;
  logic    mon_pend = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) mon_pend <= rd_vld;

  // monitor: read results one cycle after the request, busy length at done
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk);
      if (mon_pend) begin
        if (rq.size() == 0) begin
          chk("rd_unexpected", 1, 0);
        end else begin
          e = rq.pop_front();
          chk($sformatf("rd%0d_x", e.tag), 32'(rd_xpos), 32'(e.x));
          chk($sformatf("rd%0d_y", e.tag), 32'(rd_ypos), 32'(e.y));
          chk($sformatf("rd%0d_sc", e.tag), 32'(spawn_cnt), 32'(e.sc));
        end
      end
      if (busy === 1'b1) bcnt++;
      else bcnt = 0;
      if (update_done === 1'b1) begin
        if (dq.size() == 0) chk("spurious_done", 1, 0);
        else chk("busy_len", bcnt, dq.pop_front());
      end
    end
  end

  task automatic rd(input int i, input int x, input int y,
                    input int sc);
    rd_exp_t e;
    e.tag = i;
    e.x   = 11'(x);
    e.y   = 11'(y);
    e.sc  = 8'(sc);
    @(negedge clk);
    rd_idx = 2'(i);
    rd_vld = 1'b1;
    rq.push_back(e);
    @(negedge clk);
    rd_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("idle_timeout", 1, 0);
  endtask

  task automatic frame(input logic s);
    @(negedge clk);
    frame_tick = 1'b1;
    scroll_req = s;
    dq.push_back(5);
    @(negedge clk);
    frame_tick = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(update_done), 0);
    chk("rst_spawn", 32'(spawn_cnt), 0);
    chk("rst_rdx", 32'(rd_xpos), 0);
    chk("rst_rdy", 32'(rd_ypos), 0);
    for (int i = 0; i < 4; i++) rd(i, 325, i * 150, 0);

    // first scrolled frame
    frame(1'b1);
    for (int i = 0; i < 4; i++) rd(i, 325, i * 150 + 2, 0);

    // 73 more frames put slot 3 at 598, the next one wraps it
    for (int f = 0; f < 73; f++) frame(1'b1);
    rd(3, 325, 598, 0);
    frame(1'b1);
    rd(0, 325, 150, 1);
    rd(1, 325, 300, 1);
    rd(2, 325, 450, 1);
    rd(3, 451, 0, 1);

    // unscrolled frame; scroll_req toggled mid-update has no effect
    @(negedge clk);
    frame_tick = 1'b1;
    scroll_req = 1'b0;
    dq.push_back(5);
    @(negedge clk);
    frame_tick = 1'b0;
    scroll_req = 1'b1;
    @(negedge clk);
    scroll_req = 1'b0;
    wait_idle();
    rd(0, 325, 150, 1);
    rd(3, 451, 0, 1);

    // 75 frames wrap slot 2; LFSR 0x59C3 -> 0xB387, 903 folds to 253
    for (int f = 0; f < 75; f++) frame(1'b1);
    rd(0, 325, 300, 2);
    rd(1, 325, 450, 2);
    rd(2, 253, 0, 2);
    rd(3, 451, 150, 2);

    // tick while busy ignored, module_en drops mid-update
    @(negedge clk);
    frame_tick = 1'b1;
    scroll_req = 1'b1;
    dq.push_back(5);
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    frame_tick = 1'b1;
    module_en  = 1'b0;
    @(negedge clk);
    frame_tick = 1'b0;
    wait_idle();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("en_off_busy", 32'(busy), 0);
      @(negedge clk);
    end
    module_en = 1'b1;
    rd(0, 325, 302, 2);
    rd(1, 325, 452, 2);
    rd(2, 253, 2, 2);
    rd(3, 451, 152, 2);

    // reset in the middle of an update
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_done", 32'(update_done), 0);
    chk("mrst_spawn", 32'(spawn_cnt), 0);
    chk("mrst_rdx", 32'(rd_xpos), 0);
    for (int i = 0; i < 4; i++) rd(i, 325, i * 150, 0);

    repeat (8) @(negedge clk);
    chk("rq_empty", rq.size(), 0);
    chk("dq_empty", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
